// File: rtl/data_mem_pkg.sv
// Shared encodings and decode helpers for the data memory controller:
// access sizes, FSM states, byte-lane mask and misalignment check.
package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << offset;
      SIZE_HALF: lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: lane_mask = 4'b1111;
      default:   lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    misaligned = ((size == SIZE_HALF) && offset[0])
              || ((size == SIZE_WORD) && (offset != 2'b00))
              || (size == SIZE_RSVD);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/half/word from a little-endian 32-bit memory word
// and sign- or zero-extends it to 32 bits.
module mem_load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*offset +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: result = zero_ext ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SIZE_HALF: result = zero_ext ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      SIZE_WORD: result = word;
      default:   result = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with valid/ready request port, sized loads/stores,
// misalignment detection, 1-cycle registered response and post-reset clear sweep.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  init_busy
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;

  generate
    if (DATA_WIDTH != 32) begin : g_width_check
      $error("data_memory_ctrl supports DATA_WIDTH = 32 only");
    end
  endgenerate

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [31:0]      mem [DEPTH];

  logic             accept;
  logic             err;
  logic             store_en;
  logic [IDX_W-1:0] idx;
  logic [3:0]       lane_en;
  logic [31:0]      lane_data;
  logic [31:0]      load_word;
  logic [31:0]      load_ext;

  assign accept    = req_valid & req_ready;
  assign idx       = req_addr[ADDR_WIDTH-1:2];
  assign err       = misaligned(req_size, req_addr[1:0]);
  assign store_en  = accept & req_write & ~err;
  assign lane_en   = lane_mask(req_size, req_addr[1:0]);
  assign load_word = mem[idx];

  // Replicate the right-aligned store data across lanes; the mask picks the live ones.
  always_comb begin
    case (req_size)
      SIZE_BYTE: lane_data = {4{req_wdata[7:0]}};
      SIZE_HALF: lane_data = {2{req_wdata[15:0]}};
      default:   lane_data = req_wdata;
    endcase
  end

  mem_load_align u_align (
    .word     (load_word),
    .offset   (req_addr[1:0]),
    .size     (req_size),
    .zero_ext (req_unsigned),
    .result   (load_ext)
  );

  // Storage: the clear sweep owns the array while in INIT.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= 32'd0;
    end else if (store_en) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_en[l]) mem[idx][8*l +: 8] <= lane_data[8*l +: 8];
      end
    end
  end

  // Control FSM and response stage (responses land one cycle after accept).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
      cnt        <= '0;
      req_ready  <= 1'b0;
      init_busy  <= (INIT_CLEAR != 0);
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      resp_valid <= accept;
      resp_err   <= accept & err;
      resp_rdata <= (accept & ~req_write & ~err) ? load_ext : 32'd0;
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state     <= ST_READY;
            req_ready <= 1'b1;
            init_busy <= 1'b0;
          end
        end
        default: begin
          req_ready <= 1'b1;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl (16-word instance with clear sweep):
// hand-computed loads/stores, extension, misalignment and mid-sweep reset.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [5:0]  req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rd;
  logic        er;
  logic        vl;

  always #5 clk = ~clk;

  data_memory_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .INIT_CLEAR(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .init_busy    (init_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request, let it be accepted at the next edge, capture the response.
  task automatic xfer(input logic wr, input logic [5:0] a, input logic [1:0] sz,
                      input logic uns, input logic [31:0] wd,
                      output logic [31:0] r, output logic e, output logic v);
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = uns;
    req_wdata    = wd;
    @(posedge clk); #1;
    r = resp_rdata;
    e = resp_err;
    v = resp_valid;
    req_valid = 1'b0;
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_busy"}, {31'd0, init_busy}, 32'd1);
      chk({tag, "_nrdy"}, {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_done_busy"}, {31'd0, init_busy}, 32'd0);
    chk({tag, "_done_rdy"},  {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;
    #1;
    chk("rst_busy",  {31'd0, init_busy},  32'd1);
    chk("rst_rdy",   {31'd0, req_ready},  32'd0);
    chk("rst_vld",   {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata,          32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    sweep_check("sweep1");

    xfer(1'b0, 6'h3C, 2'b10, 1'b0, 32'd0, rd, er, vl);
    chk("ld3c_vld", {31'd0, vl}, 32'd1);
    chk("ld3c", rd, 32'h0000_0000);
    chk("ld3c_err", {31'd0, er}, 32'd0);
    @(posedge clk); #1;
    chk("vld_drop", {31'd0, resp_valid}, 32'd0);

    xfer(1'b1, 6'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, er, vl);
    chk("st10_rdata", rd, 32'd0);
    chk("st10_vld", {31'd0, vl}, 32'd1);
    xfer(1'b1, 6'h11, 2'b00, 1'b0, 32'hFFFF_FF5A, rd, er, vl);
    xfer(1'b0, 6'h10, 2'b10, 1'b0, 32'd0, rd, er, vl);
    chk("ld10_word", rd, 32'hDEAD5AEF);
    xfer(1'b0, 6'h12, 2'b00, 1'b0, 32'd0, rd, er, vl);
    chk("ld12_sbyte", rd, 32'hFFFFFFAD);
    xfer(1'b0, 6'h12, 2'b00, 1'b1, 32'd0, rd, er, vl);
    chk("ld12_ubyte", rd, 32'h000000AD);

    xfer(1'b1, 6'h06, 2'b01, 1'b0, 32'h0000_8001, rd, er, vl);
    xfer(1'b0, 6'h06, 2'b01, 1'b0, 32'd0, rd, er, vl);
    chk("ld06_shalf", rd, 32'hFFFF8001);
    xfer(1'b0, 6'h06, 2'b01, 1'b1, 32'd0, rd, er, vl);
    chk("ld06_uhalf", rd, 32'h00008001);
    xfer(1'b0, 6'h04, 2'b10, 1'b0, 32'd0, rd, er, vl);
    chk("ld04_word", rd, 32'h80010000);

    xfer(1'b1, 6'h00, 2'b10, 1'b0, 32'h12345678, rd, er, vl);
    xfer(1'b1, 6'h02, 2'b10, 1'b0, 32'hCAFEF00D, rd, er, vl);
    chk("mis_st_err", {31'd0, er}, 32'd1);
    chk("mis_st_rdata", rd, 32'd0);
    xfer(1'b0, 6'h03, 2'b01, 1'b0, 32'd0, rd, er, vl);
    chk("mis_ld_err", {31'd0, er}, 32'd1);
    chk("mis_ld_rdata", rd, 32'd0);
    xfer(1'b1, 6'h00, 2'b11, 1'b0, 32'hFFFFFFFF, rd, er, vl);
    chk("rsvd_err", {31'd0, er}, 32'd1);
    chk("rsvd_vld", {31'd0, vl}, 32'd1);
    xfer(1'b0, 6'h00, 2'b10, 1'b0, 32'd0, rd, er, vl);
    chk("ld00_intact", rd, 32'h12345678);
    chk("ld00_err", {31'd0, er}, 32'd0);

    // Store then load on consecutive edges.
    xfer(1'b1, 6'h20, 2'b10, 1'b0, 32'h11223344, rd, er, vl);
    chk("b2b_st_vld", {31'd0, vl}, 32'd1);
    xfer(1'b0, 6'h20, 2'b10, 1'b0, 32'd0, rd, er, vl);
    chk("b2b_ld", rd, 32'h11223344);
    chk("b2b_ld_vld", {31'd0, vl}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_vld_drop", {31'd0, resp_valid}, 32'd0);

    xfer(1'b1, 6'h3C, 2'b10, 1'b0, 32'hA5A5C3C3, rd, er, vl);
    xfer(1'b0, 6'h3E, 2'b01, 1'b1, 32'd0, rd, er, vl);
    chk("top_uhalf", rd, 32'h0000A5A5);

    // Reset, then reset again five cycles into the sweep.
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    repeat (5) @(posedge clk);
    #2; reset = 1'b1;
    #1;
    chk("mid_busy", {31'd0, init_busy},  32'd1);
    chk("mid_rdy",  {31'd0, req_ready},  32'd0);
    chk("mid_vld",  {31'd0, resp_valid}, 32'd0);
    chk("mid_err",  {31'd0, resp_err},   32'd0);
    @(negedge clk); reset = 1'b0;
    #1;
    sweep_check("sweep2");
    xfer(1'b0, 6'h10, 2'b10, 1'b0, 32'd0, rd, er, vl);
    chk("clr10", rd, 32'd0);
    xfer(1'b0, 6'h20, 2'b10, 1'b0, 32'd0, rd, er, vl);
    chk("clr20", rd, 32'd0);
    xfer(1'b0, 6'h3C, 2'b10, 1'b0, 32'd0, rd, er, vl);
    chk("clr3c", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
